// File: rtl/lieat_axi_arbiter_n.sv
// lieat_axi_arbiter_n: NCLI-client AXI4 master arbiter onto one io_master port.
// Reads use a single registered AR slot and allow one outstanding burst per client;
// R beats are routed back by rid. Writes run one at a time through a 4-state FSM.
// Optional macro LIEAT_AXI_RR_EN: round-robin arbitration with separate AR/AW pointers;
// when undefined the lowest client index wins.
module lieat_axi_arbiter_n #(
    parameter int unsigned NCLI = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 64,
    parameter int unsigned IDW  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    // client read side
    input  logic [NCLI-1:0]        cli_arvalid,
    output logic [NCLI-1:0]        cli_arready,
    input  logic [NCLI*AW-1:0]     cli_araddr,
    input  logic [NCLI*3-1:0]      cli_arsize,
    input  logic [NCLI*8-1:0]      cli_arlen,
    output logic [NCLI-1:0]        cli_rvalid,
    input  logic [NCLI-1:0]        cli_rready,
    output logic [DW-1:0]          cli_rdata,
    output logic [1:0]             cli_rresp,
    output logic                   cli_rlast,
    // client write side
    input  logic [NCLI-1:0]        cli_awvalid,
    output logic [NCLI-1:0]        cli_awready,
    input  logic [NCLI*AW-1:0]     cli_awaddr,
    input  logic [NCLI*3-1:0]      cli_awsize,
    input  logic [NCLI*8-1:0]      cli_awlen,
    input  logic [NCLI-1:0]        cli_wvalid,
    output logic [NCLI-1:0]        cli_wready,
    input  logic [NCLI-1:0]        cli_wlast,
    input  logic [NCLI*DW-1:0]     cli_wdata,
    input  logic [NCLI*(DW/8)-1:0] cli_wstrb,
    output logic [NCLI-1:0]        cli_bvalid,
    input  logic [NCLI-1:0]        cli_bready,
    output logic [1:0]             cli_bresp,
    // SoC master AR/R
    output logic                   io_master_arvalid,
    input  logic                   io_master_arready,
    output logic [AW-1:0]          io_master_araddr,
    output logic [IDW-1:0]         io_master_arid,
    output logic [7:0]             io_master_arlen,
    output logic [2:0]             io_master_arsize,
    output logic [1:0]             io_master_arburst,
    input  logic                   io_master_rvalid,
    output logic                   io_master_rready,
    input  logic [DW-1:0]          io_master_rdata,
    input  logic [1:0]             io_master_rresp,
    input  logic                   io_master_rlast,
    input  logic [IDW-1:0]         io_master_rid,
    // SoC master AW/W/B
    output logic                   io_master_awvalid,
    input  logic                   io_master_awready,
    output logic [AW-1:0]          io_master_awaddr,
    output logic [IDW-1:0]         io_master_awid,
    output logic [7:0]             io_master_awlen,
    output logic [2:0]             io_master_awsize,
    output logic [1:0]             io_master_awburst,
    output logic                   io_master_wvalid,
    input  logic                   io_master_wready,
    output logic [DW-1:0]          io_master_wdata,
    output logic [DW/8-1:0]        io_master_wstrb,
    output logic                   io_master_wlast,
    input  logic                   io_master_bvalid,
    output logic                   io_master_bready,
    input  logic [1:0]             io_master_bresp,
    input  logic [IDW-1:0]         io_master_bid,
    output logic                   rd_err
);

    localparam int unsigned CW = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam int unsigned SB = DW / 8;

    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} wstate_e;

    // First requester found when scanning upward from start, wrapping at NCLI.
    function automatic logic [CW-1:0] pick(input logic [NCLI-1:0] req,
                                           input logic [CW-1:0] start);
        logic found;
        int   idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NCLI; i++) begin
            idx = (int'(start) + i) % NCLI;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = CW'(idx);
            end
        end
    endfunction

    logic            slot_q, rd_err_q, ar_grant, rid_hit;
    logic [NCLI-1:0] rd_busy_q, ar_elig, rd_clr;
    logic [CW-1:0]   ar_win, ar_id_q, ar_start, aw_win, w_id_q, aw_start;
    logic [AW-1:0]   ar_addr_q, aw_addr_q;
    logic [7:0]      ar_len_q, aw_len_q;
    logic [2:0]      ar_size_q, aw_size_q;
    int              ar_sel, aw_sel, w_sel;
    logic            aw_grant;
    wstate_e         w_state_q, w_state_d;
    logic            unused_bid;

    assign unused_bid = ^io_master_bid;

`ifdef LIEAT_AXI_RR_EN
    logic [CW-1:0] ar_ptr_q, aw_ptr_q;
    assign ar_start = ar_ptr_q;
    assign aw_start = aw_ptr_q;

    // Priority restarts just after the most recent winner of each channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            ar_ptr_q <= '0;
            aw_ptr_q <= '0;
        end else begin
            if (ar_grant) ar_ptr_q <= (ar_win == CW'(NCLI - 1)) ? '0 : ar_win + 1'b1;
            if (aw_grant) aw_ptr_q <= (aw_win == CW'(NCLI - 1)) ? '0 : aw_win + 1'b1;
        end
    end
`else
    assign ar_start = '0;
    assign aw_start = '0;
`endif

    // AR grant: only when the slot is empty, skipping clients with a read outstanding.
    always_comb begin
        ar_elig     = cli_arvalid & ~rd_busy_q;
        ar_win      = pick(ar_elig, ar_start);
        ar_sel      = int'(ar_win);
        ar_grant    = !reset && !slot_q && (ar_elig != '0);
        cli_arready = '0;
        if (ar_grant) cli_arready[ar_win] = 1'b1;
    end

    // R routing by rid; unknown ids are accepted and dropped.
    always_comb begin
        cli_rvalid       = '0;
        io_master_rready = 1'b1;
        rid_hit          = 1'b0;
        rd_clr           = '0;
        for (int i = 0; i < NCLI; i++) begin
            if (io_master_rid == IDW'(i)) begin
                rid_hit          = 1'b1;
                cli_rvalid[i]    = io_master_rvalid;
                io_master_rready = cli_rready[i];
                rd_clr[i]        = io_master_rvalid & cli_rready[i] & io_master_rlast;
            end
        end
    end

    // AR slot, per-client busy flags and sticky bad-rid flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q    <= 1'b0;
            rd_busy_q <= '0;
            rd_err_q  <= 1'b0;
            ar_id_q   <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_size_q <= '0;
        end else begin
            if (ar_grant) begin
                slot_q    <= 1'b1;
                ar_id_q   <= ar_win;
                ar_addr_q <= cli_araddr[ar_sel*AW +: AW];
                ar_len_q  <= cli_arlen[ar_sel*8 +: 8];
                ar_size_q <= cli_arsize[ar_sel*3 +: 3];
            end else if (slot_q && io_master_arready) begin
                slot_q <= 1'b0;
            end
            // Busy set and clear never hit the same client in one cycle.
            rd_busy_q <= (rd_busy_q & ~rd_clr) | cli_arready;
            if (io_master_rvalid && !rid_hit) rd_err_q <= 1'b1;
        end
    end

    assign io_master_arvalid = slot_q;
    assign io_master_araddr  = ar_addr_q;
    assign io_master_arid    = IDW'(ar_id_q);
    assign io_master_arlen   = ar_len_q;
    assign io_master_arsize  = ar_size_q;
    assign io_master_arburst = 2'b01;
    assign cli_rdata         = io_master_rdata;
    assign cli_rresp         = io_master_rresp;
    assign cli_rlast         = io_master_rlast;
    assign rd_err            = rd_err_q;

    // Write FSM next state and channel muxing for the current write owner.
    always_comb begin
        w_state_d         = w_state_q;
        aw_win            = pick(cli_awvalid, aw_start);
        aw_sel            = int'(aw_win);
        w_sel             = int'(w_id_q);
        aw_grant          = 1'b0;
        cli_awready       = '0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_wdata   = cli_wdata[w_sel*DW +: DW];
        io_master_wstrb   = cli_wstrb[w_sel*SB +: SB];
        io_master_wlast   = cli_wlast[w_id_q];
        cli_wready        = '0;
        cli_bvalid        = '0;
        io_master_bready  = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                if (!reset && (cli_awvalid != '0)) begin
                    aw_grant            = 1'b1;
                    cli_awready[aw_win] = 1'b1;
                    w_state_d           = WAddr;
                end
            end
            WAddr: begin
                io_master_awvalid = 1'b1;
                if (io_master_awready) w_state_d = WData;
            end
            WData: begin
                io_master_wvalid   = cli_wvalid[w_id_q];
                cli_wready[w_id_q] = io_master_wready;
                if (cli_wvalid[w_id_q] && io_master_wready && cli_wlast[w_id_q]) begin
                    w_state_d = WResp;
                end
            end
            WResp: begin
                cli_bvalid[w_id_q] = io_master_bvalid;
                io_master_bready   = cli_bready[w_id_q];
                if (io_master_bvalid && cli_bready[w_id_q]) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Write FSM state and latched AW fields.
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            aw_size_q <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_grant) begin
                w_id_q    <= aw_win;
                aw_addr_q <= cli_awaddr[aw_sel*AW +: AW];
                aw_len_q  <= cli_awlen[aw_sel*8 +: 8];
                aw_size_q <= cli_awsize[aw_sel*3 +: 3];
            end
        end
    end

    assign io_master_awaddr  = aw_addr_q;
    assign io_master_awid    = IDW'(w_id_q);
    assign io_master_awlen   = aw_len_q;
    assign io_master_awsize  = aw_size_q;
    assign io_master_awburst = 2'b01;
    assign cli_bresp         = io_master_bresp;

endmodule

// File: tb/tb_lieat_axi_arbiter_n.sv
// Randomized bench for lieat_axi_arbiter_n with NCLI=2: random clients and a random
// out-of-order slave, every output checked each cycle against a transaction-level model.
module tb_lieat_axi_arbiter_n;
    localparam int NCLI = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IDW = 4;
    localparam int SB = DW / 8;
    localparam int NCYC = 3000;
    localparam int RST_AT = 1500;

    logic clock, reset;
    logic [NCLI-1:0] cli_arvalid, cli_arready, cli_rvalid, cli_rready;
    logic [NCLI*AW-1:0] cli_araddr, cli_awaddr;
    logic [NCLI*3-1:0] cli_arsize, cli_awsize;
    logic [NCLI*8-1:0] cli_arlen, cli_awlen;
    logic [DW-1:0] cli_rdata;
    logic [1:0] cli_rresp, cli_bresp;
    logic cli_rlast;
    logic [NCLI-1:0] cli_awvalid, cli_awready, cli_wvalid, cli_wready, cli_wlast;
    logic [NCLI*DW-1:0] cli_wdata;
    logic [NCLI*SB-1:0] cli_wstrb;
    logic [NCLI-1:0] cli_bvalid, cli_bready;
    logic io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready;
    logic [AW-1:0] io_master_araddr, io_master_awaddr;
    logic [IDW-1:0] io_master_arid, io_master_rid, io_master_awid, io_master_bid;
    logic [7:0] io_master_arlen, io_master_awlen;
    logic [2:0] io_master_arsize, io_master_awsize;
    logic [1:0] io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
    logic [DW-1:0] io_master_rdata, io_master_wdata;
    logic io_master_rlast, io_master_awvalid, io_master_awready, io_master_wvalid;
    logic io_master_wready, io_master_wlast, io_master_bvalid, io_master_bready;
    logic [SB-1:0] io_master_wstrb;
    logic rd_err;

    lieat_axi_arbiter_n #(.NCLI(NCLI), .AW(AW), .DW(DW), .IDW(IDW)) dut (
        .clock(clock), .reset(reset),
        .cli_arvalid(cli_arvalid), .cli_arready(cli_arready), .cli_araddr(cli_araddr),
        .cli_arsize(cli_arsize), .cli_arlen(cli_arlen), .cli_rvalid(cli_rvalid),
        .cli_rready(cli_rready), .cli_rdata(cli_rdata), .cli_rresp(cli_rresp),
        .cli_rlast(cli_rlast), .cli_awvalid(cli_awvalid), .cli_awready(cli_awready),
        .cli_awaddr(cli_awaddr), .cli_awsize(cli_awsize), .cli_awlen(cli_awlen),
        .cli_wvalid(cli_wvalid), .cli_wready(cli_wready), .cli_wlast(cli_wlast),
        .cli_wdata(cli_wdata), .cli_wstrb(cli_wstrb), .cli_bvalid(cli_bvalid),
        .cli_bready(cli_bready), .cli_bresp(cli_bresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst), .io_master_rvalid(io_master_rvalid),
        .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
        .io_master_rid(io_master_rid), .io_master_awvalid(io_master_awvalid),
        .io_master_awready(io_master_awready), .io_master_awaddr(io_master_awaddr),
        .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
        .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast), .io_master_bvalid(io_master_bvalid),
        .io_master_bready(io_master_bready), .io_master_bresp(io_master_bresp),
        .io_master_bid(io_master_bid), .rd_err(rd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NCLI-1:0] req, input int start);
        for (int i = 0; i < NCLI; i++) begin
            if (req[(start + i) % NCLI]) return (start + i) % NCLI;
        end
        return -1;
    endfunction

    function automatic logic [NCLI-1:0] oh(input int k);
        logic [NCLI-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    // Client request state
    logic [NCLI-1:0] rq_v, wq_v;
    logic [AW-1:0] rq_addr[NCLI], wq_addr[NCLI];
    int rq_len[NCLI], wq_len[NCLI];
    // Slave state
    int pend_id[$], pend_left[$];
    bit r_act, b_act;
    int r_k;
    // Reference model
    bit m_slot, m_err;
    logic [NCLI-1:0] m_busy;
    int m_arptr, m_awptr, m_arid, m_arlen, m_wph, m_wid, m_awlen, m_wcnt;
    logic [AW-1:0] m_araddr, m_awaddr;

    task automatic clear_all();
        rq_v = '0; wq_v = '0; r_act = 0; b_act = 0; r_k = 0;
        pend_id.delete(); pend_left.delete();
        m_slot = 0; m_err = 0; m_busy = '0; m_arptr = 0; m_awptr = 0;
        m_arid = 0; m_arlen = 0; m_wph = 0; m_wid = 0; m_awlen = 0; m_wcnt = 0;
        m_araddr = '0; m_awaddr = '0;
    endtask

    task automatic do_cycle(input bit rst);
        int exp_ar, exp_aw, sa, sw;
        bit rid_ok;
        @(negedge clock);
        reset = rst;
        // Clients
        for (int i = 0; i < NCLI; i++) begin
            if (!rq_v[i] && $urandom_range(3) == 0) begin
                rq_v[i] = 1'b1; rq_addr[i] = $urandom; rq_len[i] = $urandom_range(3);
            end
            if (!wq_v[i] && $urandom_range(5) == 0) begin
                wq_v[i] = 1'b1; wq_addr[i] = $urandom; wq_len[i] = $urandom_range(3);
            end
            cli_arvalid[i] = rq_v[i];
            cli_araddr[i*AW +: AW] = rq_addr[i];
            cli_arlen[i*8 +: 8] = 8'(rq_len[i]);
            cli_arsize[i*3 +: 3] = 3'd3;
            cli_awvalid[i] = wq_v[i];
            cli_awaddr[i*AW +: AW] = wq_addr[i];
            cli_awlen[i*8 +: 8] = 8'(wq_len[i]);
            cli_awsize[i*3 +: 3] = 3'd2;
            cli_rready[i] = 1'($urandom_range(1));
            cli_bready[i] = 1'($urandom_range(1));
            cli_wvalid[i] = 1'($urandom_range(1));
            cli_wlast[i] = 1'($urandom_range(1));
            cli_wdata[i*DW +: DW] = {$urandom, $urandom};
            cli_wstrb[i*SB +: SB] = 8'($urandom);
        end
        if (m_wph == 2) cli_wlast[m_wid] = (m_wcnt == m_awlen);
        // Slave
        io_master_arready = 1'($urandom_range(1));
        io_master_awready = 1'($urandom_range(1));
        io_master_wready = 1'($urandom_range(1));
        io_master_bid = 4'($urandom);
        if (!r_act) begin
            if (pend_id.size() > 0 && $urandom_range(1) == 1) begin
                r_k = $urandom_range(pend_id.size() - 1);
                r_act = 1;
                io_master_rid = IDW'(pend_id[r_k]);
                io_master_rlast = (pend_left[r_k] == 0);
                io_master_rdata = {$urandom, $urandom};
                io_master_rresp = 2'($urandom);
            end else if ($urandom_range(59) == 0) begin
                r_k = -1;
                r_act = 1;
                io_master_rid = 4'd5;
                io_master_rlast = 1'($urandom_range(1));
                io_master_rdata = {$urandom, $urandom};
                io_master_rresp = 2'($urandom);
            end
        end
        io_master_rvalid = r_act;
        if (m_wph == 3 && !b_act && $urandom_range(1) == 1) begin
            b_act = 1;
            io_master_bresp = 2'($urandom);
        end
        io_master_bvalid = b_act;
        #1;
`ifdef LIEAT_AXI_RR_EN
        sa = m_arptr; sw = m_awptr;
`else
        sa = 0; sw = 0;
`endif
        exp_ar = (!rst && !m_slot) ? pick(rq_v & ~m_busy, sa) : -1;
        exp_aw = (!rst && m_wph == 0) ? pick(wq_v, sw) : -1;
        // Read checks
        check_val("cli_arready", 64'(cli_arready), 64'(oh(exp_ar)));
        check_val("io_arvalid", 64'(io_master_arvalid), 64'(m_slot));
        if (m_slot) begin
            check_val("io_araddr", 64'(io_master_araddr), 64'(m_araddr));
            check_val("io_arid", 64'(io_master_arid), 64'(m_arid));
            check_val("io_arlen", 64'(io_master_arlen), 64'(m_arlen));
            check_val("io_arsize", 64'(io_master_arsize), 64'd3);
            check_val("io_arburst", 64'(io_master_arburst), 64'd1);
        end
        rid_ok = r_act && (r_k >= 0);
        check_val("cli_rvalid", 64'(cli_rvalid), rid_ok ? 64'(oh(pend_id[r_k])) : 64'd0);
        if (r_act) begin
            check_val("io_rready", 64'(io_master_rready),
                      rid_ok ? 64'(cli_rready[pend_id[r_k]]) : 64'd1);
        end
        if (rid_ok) begin
            check_val("cli_rdata", cli_rdata, io_master_rdata);
            check_val("cli_rlast", 64'(cli_rlast), 64'(pend_left[r_k] == 0));
            check_val("cli_rresp", 64'(cli_rresp), 64'(io_master_rresp));
        end
        check_val("rd_err", 64'(rd_err), 64'(m_err));
        // Write checks
        check_val("cli_awready", 64'(cli_awready), 64'(oh(exp_aw)));
        check_val("io_awvalid", 64'(io_master_awvalid), 64'(m_wph == 1));
        if (m_wph == 1) begin
            check_val("io_awaddr", 64'(io_master_awaddr), 64'(m_awaddr));
            check_val("io_awid", 64'(io_master_awid), 64'(m_wid));
            check_val("io_awlen", 64'(io_master_awlen), 64'(m_awlen));
            check_val("io_awburst", 64'(io_master_awburst), 64'd1);
        end
        check_val("io_wvalid", 64'(io_master_wvalid), 64'(m_wph == 2 && cli_wvalid[m_wid]));
        if (m_wph == 2) begin
            check_val("io_wdata", io_master_wdata, cli_wdata[m_wid*DW +: DW]);
            check_val("io_wstrb", 64'(io_master_wstrb), 64'(cli_wstrb[m_wid*SB +: SB]));
            check_val("io_wlast", 64'(io_master_wlast), 64'(m_wcnt == m_awlen));
        end
        check_val("cli_wready", 64'(cli_wready),
                  (m_wph == 2 && io_master_wready) ? 64'(oh(m_wid)) : 64'd0);
        check_val("cli_bvalid", 64'(cli_bvalid), (m_wph == 3 && b_act) ? 64'(oh(m_wid)) : 64'd0);
        check_val("io_bready", 64'(io_master_bready), 64'(m_wph == 3 && cli_bready[m_wid]));
        if (b_act) check_val("cli_bresp", 64'(cli_bresp), 64'(io_master_bresp));
        // Advance model for the coming edge
        if (rst) begin
            clear_all();
        end else begin
            if (exp_ar >= 0) begin
                m_slot = 1; m_arid = exp_ar; m_araddr = rq_addr[exp_ar];
                m_arlen = rq_len[exp_ar]; rq_v[exp_ar] = 1'b0; m_busy[exp_ar] = 1'b1;
                m_arptr = (exp_ar + 1) % NCLI;
            end else if (m_slot && io_master_arready) begin
                m_slot = 0;
                pend_id.push_back(m_arid);
                pend_left.push_back(m_arlen);
            end
            if (r_act) begin
                if (r_k < 0) begin
                    m_err = 1; r_act = 0;
                end else if (cli_rready[pend_id[r_k]]) begin
                    if (pend_left[r_k] == 0) begin
                        m_busy[pend_id[r_k]] = 1'b0;
                        pend_id.delete(r_k);
                        pend_left.delete(r_k);
                    end else begin
                        pend_left[r_k] = pend_left[r_k] - 1;
                    end
                    r_act = 0;
                end
            end
            case (m_wph)
                0: if (exp_aw >= 0) begin
                    m_wph = 1; m_wid = exp_aw; m_awaddr = wq_addr[exp_aw];
                    m_awlen = wq_len[exp_aw]; wq_v[exp_aw] = 1'b0; m_wcnt = 0;
                    m_awptr = (exp_aw + 1) % NCLI;
                end
                1: if (io_master_awready) m_wph = 2;
                2: if (cli_wvalid[m_wid] && io_master_wready) begin
                    if (m_wcnt == m_awlen) m_wph = 3;
                    else m_wcnt++;
                end
                3: if (b_act && cli_bready[m_wid]) begin
                    b_act = 0; m_wph = 0;
                end
                default: m_wph = 0;
            endcase
        end
    endtask

    initial begin
        bit rst_done;
        reset = 1'b1;
        cli_arvalid = '0; cli_awvalid = '0; cli_wvalid = '0; cli_rready = '0;
        cli_bready = '0; cli_wlast = '0; cli_wdata = '0; cli_wstrb = '0;
        cli_araddr = '0; cli_awaddr = '0; cli_arlen = '0; cli_awlen = '0;
        cli_arsize = '0; cli_awsize = '0;
        io_master_arready = 0; io_master_awready = 0; io_master_wready = 0;
        io_master_rvalid = 0; io_master_rid = '0; io_master_rdata = '0;
        io_master_rresp = '0; io_master_rlast = 0; io_master_bvalid = 0;
        io_master_bresp = '0; io_master_bid = '0;
        clear_all();
        for (int i = 0; i < 3; i++) do_cycle(1'b1);
        // Both clients request in the first cycle out of reset.
        for (int i = 0; i < NCLI; i++) begin
            rq_v[i] = 1'b1; rq_addr[i] = 32'h8000_0000 + 32'(i * 'h100); rq_len[i] = 3;
        end
        rst_done = 0;
        for (int c = 0; c < NCYC; c++) begin
            if (!rst_done && c >= RST_AT && m_wph == 2) begin
                do_cycle(1'b1);
                rst_done = 1;
            end else begin
                do_cycle(1'b0);
            end
        end
        check_val("mid_reset_hit", 64'(rst_done), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
